// File: rtl/cam_pkg.sv
// Shared operation and state types for the CAM request arbiter.
package cam_pkg;

  typedef enum logic [1:0] {
    CAM_OP_READ   = 2'd0,
    CAM_OP_WRITE  = 2'd1,
    CAM_OP_SEARCH = 2'd2,
    CAM_OP_ILL    = 2'd3
  } cam_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESPOND
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/cam_req_arbiter.sv
// Time-shares one CAM port set between NUM_REQ requesters: round-robin grant,
// one operation in flight, response routed back to the owning requester only.
module cam_req_arbiter
  import cam_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int ARRAY_WIDTH_LOG2 = 5,
  parameter int RSP_TIMEOUT      = 8,
  localparam int AW = ARRAY_WIDTH_LOG2,
  localparam int DW = 2 ** ARRAY_WIDTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*2-1:0]  req_op_i,
  input  logic [NUM_REQ*AW-1:0] req_index_i,
  input  logic [NUM_REQ*DW-1:0] req_data_i,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  output logic [DW-1:0]         rsp_data_o,
  output logic [AW-1:0]         rsp_index_o,
  output logic                  rsp_hit_o,
  output logic                  rsp_err_o,
  output logic                  cam_read_o,
  output logic                  cam_write_o,
  output logic                  cam_search_o,
  output logic [AW-1:0]         cam_read_index_o,
  output logic [AW-1:0]         cam_write_index_o,
  output logic [DW-1:0]         cam_write_data_o,
  output logic [DW-1:0]         cam_search_data_o,
  input  logic                  cam_read_valid_i,
  input  logic                  cam_search_valid_i,
  input  logic [DW-1:0]         cam_read_value_i,
  input  logic [AW-1:0]         cam_search_index_i
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(RSP_TIMEOUT + 1);

  arb_state_e    state_q, state_d;
  cam_op_e       op_q, op_d;
  logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          cam_read_q, cam_read_d, cam_write_q, cam_write_d, cam_search_q, cam_search_d;
  logic [AW-1:0] cam_read_index_q, cam_read_index_d, cam_write_index_q, cam_write_index_d;
  logic [DW-1:0] cam_write_data_q, cam_write_data_d, cam_search_data_q, cam_search_data_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic [AW-1:0] rsp_index_q, rsp_index_d;
  logic          rsp_hit_q, rsp_hit_d, rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  cam_op_e            sel_op;
  logic [AW-1:0]      sel_index;
  logic [DW-1:0]      sel_data;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  assign sel_op    = cam_op_e'(req_op_i[int'(arb_idx) * 2 +: 2]);
  assign sel_index = req_index_i[int'(arb_idx) * AW +: AW];
  assign sel_data  = req_data_i[int'(arb_idx) * DW +: DW];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= ST_IDLE;
      op_q              <= CAM_OP_READ;
      ptr_q             <= '0;
      owner_q           <= '0;
      timer_q           <= '0;
      cam_read_q        <= 1'b0;
      cam_write_q       <= 1'b0;
      cam_search_q      <= 1'b0;
      cam_read_index_q  <= '0;
      cam_write_index_q <= '0;
      cam_write_data_q  <= '0;
      cam_search_data_q <= '0;
      rsp_data_q        <= '0;
      rsp_index_q       <= '0;
      rsp_hit_q         <= 1'b0;
      rsp_err_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      op_q              <= op_d;
      ptr_q             <= ptr_d;
      owner_q           <= owner_d;
      timer_q           <= timer_d;
      cam_read_q        <= cam_read_d;
      cam_write_q       <= cam_write_d;
      cam_search_q      <= cam_search_d;
      cam_read_index_q  <= cam_read_index_d;
      cam_write_index_q <= cam_write_index_d;
      cam_write_data_q  <= cam_write_data_d;
      cam_search_data_q <= cam_search_data_d;
      rsp_data_q        <= rsp_data_d;
      rsp_index_q       <= rsp_index_d;
      rsp_hit_q         <= rsp_hit_d;
      rsp_err_q         <= rsp_err_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    ptr_d             = ptr_q;
    owner_d           = owner_q;
    timer_d           = timer_q;
    cam_read_d        = 1'b0;
    cam_write_d       = 1'b0;
    cam_search_d      = 1'b0;
    cam_read_index_d  = cam_read_index_q;
    cam_write_index_d = cam_write_index_q;
    cam_write_data_d  = cam_write_data_q;
    cam_search_data_d = cam_search_data_q;
    rsp_data_d        = rsp_data_q;
    rsp_index_d       = rsp_index_q;
    rsp_hit_d         = rsp_hit_q;
    rsp_err_d         = rsp_err_q;
    req_ready_o       = '0;
    rsp_valid_o       = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          // Ready is masked while reset is held so nothing looks accepted.
          req_ready_o = arb_gnt & {NUM_REQ{reset}};
          owner_d     = arb_idx;
          op_d        = sel_op;
          state_d     = ST_ISSUE;
          case (sel_op)
            CAM_OP_READ: begin
              cam_read_d       = 1'b1;
              cam_read_index_d = sel_index;
            end
            CAM_OP_WRITE: begin
              cam_write_d       = 1'b1;
              cam_write_index_d = sel_index;
              cam_write_data_d  = sel_data;
            end
            CAM_OP_SEARCH: begin
              cam_search_d      = 1'b1;
              cam_search_data_d = sel_data;
            end
            default: ;
          endcase
        end
      end
      ST_ISSUE: begin
        case (op_q)
          CAM_OP_WRITE, CAM_OP_ILL: begin
            rsp_data_d  = '0;
            rsp_index_d = '0;
            rsp_hit_d   = (op_q == CAM_OP_WRITE);
            rsp_err_d   = (op_q == CAM_OP_ILL);
            state_d     = ST_RESPOND;
          end
          default: begin
            timer_d = '0;
            state_d = ST_WAIT;
          end
        endcase
      end
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A result in the final wait cycle still counts as a hit.
        if (op_q == CAM_OP_READ && cam_read_valid_i) begin
          rsp_data_d  = cam_read_value_i;
          rsp_index_d = '0;
          rsp_hit_d   = 1'b1;
          rsp_err_d   = 1'b0;
          state_d     = ST_RESPOND;
        end else if (op_q == CAM_OP_SEARCH && cam_search_valid_i) begin
          rsp_data_d  = '0;
          rsp_index_d = cam_search_index_i;
          rsp_hit_d   = 1'b1;
          rsp_err_d   = 1'b0;
          state_d     = ST_RESPOND;
        end else if (timer_q == TW'(RSP_TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_index_d = '0;
          rsp_hit_d   = 1'b0;
          rsp_err_d   = 1'b1;
          state_d     = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        rsp_valid_o[owner_q] = 1'b1;
        ptr_d   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cam_read_o        = cam_read_q;
  assign cam_write_o       = cam_write_q;
  assign cam_search_o      = cam_search_q;
  assign cam_read_index_o  = cam_read_index_q;
  assign cam_write_index_o = cam_write_index_q;
  assign cam_write_data_o  = cam_write_data_q;
  assign cam_search_data_o = cam_search_data_q;
  assign rsp_data_o        = rsp_data_q;
  assign rsp_index_o       = rsp_index_q;
  assign rsp_hit_o         = rsp_hit_q;
  assign rsp_err_o         = rsp_err_q;

endmodule

// File: tb/tb_cam_req_arbiter.sv
// Bench for cam_req_arbiter: a transaction-level model (grant order, latencies
// counted from acceptance, expected response fields) checked every cycle.
module tb_cam_req_arbiter;
  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [2*N-1:0]  req_op;
  logic [N*AW-1:0] req_index;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   rsp_data, cam_write_data, cam_search_data, cam_read_value;
  logic [AW-1:0]   rsp_index, cam_read_index, cam_write_index, cam_search_index;
  logic            rsp_hit, rsp_err, cam_read, cam_write, cam_search;
  logic            cam_read_valid, cam_search_valid;

  always #5 clk = ~clk;

  cam_req_arbiter #(.NUM_REQ(N), .ARRAY_WIDTH_LOG2(AW), .RSP_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_index_i(req_index), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_index_o(rsp_index),
    .rsp_hit_o(rsp_hit), .rsp_err_o(rsp_err),
    .cam_read_o(cam_read), .cam_write_o(cam_write), .cam_search_o(cam_search),
    .cam_read_index_o(cam_read_index), .cam_write_index_o(cam_write_index),
    .cam_write_data_o(cam_write_data), .cam_search_data_o(cam_search_data),
    .cam_read_valid_i(cam_read_valid), .cam_search_valid_i(cam_search_valid),
    .cam_read_value_i(cam_read_value), .cam_search_index_i(cam_search_index)
  );

  int n_checks = 0, n_fail = 0, cyc_n = 0;

  // Reference model state
  bit            m_busy = 0;
  int            m_cyc, m_owner, m_rsp_at, m_ptr = 0;
  logic [1:0]    m_op;
  logic [AW-1:0] m_idx, p_index, e_index = '0;
  logic [DW-1:0] m_dat, p_data, e_data = '0;
  logic          p_hit, p_err, e_hit = 0, e_err = 0;

  // Observations and stimulus state
  logic [N-1:0]  o_ready = '0, last_rv = '0;
  logic          o_rd = 0, o_wr = 0, o_se = 0, last_hit = 0, last_err = 0;
  logic [AW-1:0] o_rd_idx, o_wr_idx, rd_idx = '0;
  logic [DW-1:0] o_wr_dat, last_data = '0;
  logic [DW-1:0] cam_mem [32];
  int acc_cyc = 0, last_lat = 0, n_rsp = 0, n_strobe = 0;
  int grants[$];
  bit cont_mode = 0, rand_mode = 0;
  int cam_lat = 1, rd_cnt = -1, se_cnt = -1, stale_cnt = -1, rst_cnt = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc_n, act, exp);
    end
  endfunction

  function automatic int rr_pick(logic [N-1:0] v, int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic int g_at(int k);
    return (grants.size() > k) ? grants[k] : -1;
  endfunction

  function automatic void set_p(logic [DW-1:0] d, logic [AW-1:0] i, logic h, logic e);
    p_data = d; p_index = i; p_hit = h; p_err = e;
  endfunction

  task automatic check_cycle();
    logic [N-1:0] x_ready, x_rv;
    logic x_rd, x_wr, x_se;
    int g;
    x_ready = '0; x_rv = '0; x_rd = 0; x_wr = 0; x_se = 0;
    if (!reset) begin
      m_busy = 0; m_ptr = 0; e_data = '0; e_index = '0; e_hit = 0; e_err = 0;
    end else if (!m_busy) begin
      g = rr_pick(req_valid, m_ptr);
      if (g >= 0) begin
        x_ready[g] = 1'b1; m_busy = 1; m_cyc = 0; m_owner = g; m_rsp_at = -1;
        m_op = req_op[2*g +: 2]; m_idx = req_index[AW*g +: AW]; m_dat = req_data[DW*g +: DW];
      end
    end else begin
      m_cyc++;
      if (m_cyc == m_rsp_at) begin
        x_rv[m_owner] = 1'b1;
        e_data = p_data; e_index = p_index; e_hit = p_hit; e_err = p_err;
        m_busy = 0; m_ptr = (m_owner + 1) % N;
      end else if (m_cyc == 1) begin
        case (m_op)
          2'd0: x_rd = 1;
          2'd1: begin x_wr = 1; set_p('0, '0, 1, 0); m_rsp_at = 2; end
          2'd2: x_se = 1;
          default: begin set_p('0, '0, 0, 1); m_rsp_at = 2; end
        endcase
      end else if (m_rsp_at < 0) begin
        // Waiting: cycle m_cyc-2 of the result window.
        if (m_op == 2'd0 && cam_read_valid) begin
          set_p(cam_read_value, '0, 1, 0); m_rsp_at = m_cyc + 1;
        end else if (m_op == 2'd2 && cam_search_valid) begin
          set_p('0, cam_search_index, 1, 0); m_rsp_at = m_cyc + 1;
        end else if (m_cyc - 2 == TO - 1) begin
          set_p('0, '0, 0, 1); m_rsp_at = m_cyc + 1;
        end
      end
    end
    chk("req_ready", req_ready, x_ready);
    chk("rsp_valid", rsp_valid, x_rv);
    chk("cam_read", cam_read, x_rd);
    chk("cam_write", cam_write, x_wr);
    chk("cam_search", cam_search, x_se);
    chk("rsp_data", rsp_data, e_data);
    chk("rsp_index", rsp_index, e_index);
    chk("rsp_hit", rsp_hit, e_hit);
    chk("rsp_err", rsp_err, e_err);
    if (x_rd) chk("cam_read_index", cam_read_index, m_idx);
    if (x_wr) begin
      chk("cam_write_index", cam_write_index, m_idx);
      chk("cam_write_data", cam_write_data, m_dat);
    end
    if (x_se) chk("cam_search_data", cam_search_data, m_dat);
    if (!reset) chk("reset_cam_regs", {cam_read_index, cam_write_index, cam_write_data, cam_search_data}, '0);

    o_ready = req_ready; o_rd = cam_read; o_wr = cam_write; o_se = cam_search;
    o_rd_idx = cam_read_index; o_wr_idx = cam_write_index; o_wr_dat = cam_write_data;
    if (cam_read || cam_write || cam_search) n_strobe++;
    if (req_ready != '0) begin
      acc_cyc = cyc_n;
      for (int i = 0; i < N; i++) if (req_ready[i]) grants.push_back(i);
    end
    if (rsp_valid != '0) begin
      last_rv = rsp_valid; last_data = rsp_data; last_hit = rsp_hit; last_err = rsp_err;
      last_lat = cyc_n - acc_cyc; n_rsp++;
    end
  endtask

  function automatic int pick_lat();
    if (!rand_mode) return cam_lat;
    return ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, TO + 2));
  endfunction

  task automatic push_req(int i, logic [1:0] op, logic [AW-1:0] idx, logic [DW-1:0] dat);
    req_op[2*i +: 2] = op; req_index[AW*i +: AW] = idx; req_data[DW*i +: DW] = dat;
    req_valid[i] = 1'b1;
  endtask

  task automatic update_stim();
    int r;
    for (int i = 0; i < N; i++) if (req_valid[i] && o_ready[i] && !cont_mode) req_valid[i] = 1'b0;
    if (rand_mode) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 9);
          push_req(i, (r == 9) ? 2'd3 : 2'(r / 3), AW'($urandom), $urandom);
        end
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) reset = 1'b1;
      end else if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0; rst_cnt = $urandom_range(1, 3);
      end
    end
    cam_read_valid = 0; cam_search_valid = 0;
    cam_read_value = $urandom; cam_search_index = AW'($urandom);
    if (o_wr) cam_mem[o_wr_idx] = o_wr_dat;
    if (o_rd) begin rd_cnt = pick_lat(); rd_idx = o_rd_idx; end
    if (o_se) se_cnt = pick_lat();
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin cam_read_valid = 1; cam_read_value = cam_mem[rd_idx]; rd_cnt = -1; end
    end
    if (se_cnt > 0) begin
      se_cnt--;
      if (se_cnt == 0) begin cam_search_valid = 1; se_cnt = -1; end
    end
    if (rand_mode && $urandom_range(0, 15) == 0) cam_read_valid = 1;
    if (rand_mode && $urandom_range(0, 15) == 0) cam_search_valid = 1;
    if (stale_cnt > 0) begin
      stale_cnt--;
      if (stale_cnt == 0) begin cam_read_valid = 1; stale_cnt = -1; end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc_n++;
    check_cycle();
    @(posedge clk);
    #1;
    update_stim();
  endtask

  task automatic run_quiet(int budget);
    int k = 0;
    tick();
    while ((req_valid != '0 || m_busy) && k < budget) begin tick(); k++; end
    chk("drain_budget", (req_valid != '0 || m_busy), 0);
  endtask

  initial begin
    int n0;
    req_valid = '0; req_op = '0; req_index = '0; req_data = '0;
    cam_read_valid = 0; cam_search_valid = 0; cam_read_value = '0; cam_search_index = '0;
    for (int i = 0; i < 32; i++) cam_mem[i] = '0;

    // Reset held with random requests, then release with requesters 1 and 2 valid
    for (int k = 0; k < 6; k++) begin
      req_valid = N'($urandom); req_op = 8'h55;
      tick();
    end
    req_valid = 4'b0110;
    #2 chk("reset_no_ready", req_ready, '0);
    grants.delete();
    reset = 1'b1;
    run_quiet(50);
    chk("first_grant", g_at(0), 1);
    chk("second_grant", g_at(1), 2);

    // Write then read back through the CAM memory model
    cam_lat = 2; n0 = n_strobe;
    push_req(0, 2'd1, 5'd3, 32'hDEADBEEF);
    run_quiet(50);
    chk("wr_rsp_vec", last_rv, 4'b0001);
    chk("wr_hit", last_hit, 1);
    chk("wr_lat", last_lat, 2);
    chk("wr_strobe_cycles", n_strobe - n0, 1);
    push_req(0, 2'd0, 5'd3, '0);
    run_quiet(50);
    chk("rd_data", last_data, 32'hDEADBEEF);
    chk("rd_hit", last_hit, 1);
    chk("rd_lat", last_lat, 4);

    // Round-robin from a fresh pointer with everyone continuously requesting
    reset = 1'b0; tick(); tick(); reset = 1'b1;
    grants.delete(); cont_mode = 1;
    for (int i = 0; i < N; i++) push_req(i, 2'd1, AW'(i), $urandom);
    for (int k = 0; k < 60 && grants.size() < 5; k++) tick();
    cont_mode = 0;
    run_quiet(100);
    for (int k = 0; k < 5; k++) chk("rr_order", g_at(k), k % N);

    // Search timeout, then a result landing exactly in the last wait cycle
    cam_lat = -1;
    push_req(1, 2'd2, '0, 32'h12345678);
    run_quiet(60);
    chk("to_rsp_vec", last_rv, 4'b0010);
    chk("to_hit", last_hit, 0);
    chk("to_err", last_err, 1);
    chk("to_lat", last_lat, TO + 2);
    cam_lat = TO;
    push_req(1, 2'd2, '0, 32'h12345678);
    run_quiet(60);
    chk("edge_hit", last_hit, 1);
    chk("edge_err", last_err, 0);
    chk("edge_lat", last_lat, TO + 2);

    // Illegal op
    n0 = n_strobe;
    push_req(2, 2'd3, '0, '0);
    run_quiet(50);
    chk("ill_rsp_vec", last_rv, 4'b0100);
    chk("ill_err", last_err, 1);
    chk("ill_hit", last_hit, 0);
    chk("ill_no_strobe", n_strobe - n0, 0);

    // Reset during WAIT with a late read valid after release
    cam_lat = -1;
    push_req(0, 2'd0, 5'd5, '0);
    for (int k = 0; k < 4; k++) tick();
    n0 = n_rsp;
    reset = 1'b0; tick(); tick();
    reset = 1'b1; stale_cnt = 1;
    for (int k = 0; k < 4; k++) tick();
    chk("rst_no_rsp", n_rsp - n0, 0);
    push_req(3, 2'd1, 5'd7, $urandom);
    run_quiet(50);
    chk("post_rst_vec", last_rv, 4'b1000);
    chk("post_rst_hit", last_hit, 1);

    // Randomized traffic
    n0 = n_rsp;
    rand_mode = 1;
    for (int k = 0; k < 3000; k++) tick();
    rand_mode = 0;
    reset = 1'b1; rst_cnt = 0;
    run_quiet(400);
    chk("random_rsp_count_ok", (n_rsp - n0) > 100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
